// File: rtl/clock24_pkg.sv
// clock24_pkg: shared types and default constants for the clock24 design.
// Used by clock_ctrl and by the display stage, which decodes MODE.
//   mode_t       : RUN / SET_HOUR / SET_MIN, 2-bit encoding (2'b11 unused)
//   CLK_HZ       : board clock frequency
//   *_DEF        : default divider / debounce / repeat lengths in CLK cycles
package clock24_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_t;

  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned TICK_DIV_DEF = CLK_HZ;          // 1 Hz seconds enable
  localparam int unsigned DB_CNT_DEF   = 1_000_000;       // 20 ms debounce
  localparam int unsigned REP_DIV_DEF  = CLK_HZ / 4;      // 4 Hz auto-repeat

  // Mode sequence on a MODE key press; anything unexpected returns to RUN.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_RUN:      return MODE_SET_HOUR;
      MODE_SET_HOUR: return MODE_SET_MIN;
      default:       return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchroniser + debouncer for one active-low push-button.
//   CLK     : system clock
//   RST     : synchronous active-high reset (key reads as released)
//   KEY_N   : raw button, active-low, asynchronous to CLK
//   PRESSED : debounced level, 1 while the key is held
//   PRESS   : one-cycle pulse per accepted press (release gives nothing)
module key_debounce
  import clock24_pkg::*;
#(
  parameter int unsigned DB_CNT = DB_CNT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY_N,
  output logic PRESSED,
  output logic PRESS
);

  localparam int unsigned   W    = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [W-1:0]  LAST = W'(DB_CNT - 1);

  logic         sync1, sync2;
  logic         deb, deb_q;
  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      deb   <= 1'b1;
      deb_q <= 1'b1;
      cnt   <= '0;
      PRESS <= 1'b0;
    end else begin
      sync1 <= KEY_N;
      sync2 <= sync1;
      deb_q <= deb;
      // Falling edge of the debounced level, one cycle after it is accepted.
      PRESS <= deb_q & ~deb;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // DB_CNT consecutive disagreeing samples: accept the new level.
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign PRESSED = ~deb;

endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: control front-end of clock24, upstream of the s/m/h counters.
//   CLK, RST    : system clock, synchronous active-high reset
//   KEY_MODE_N  : raw mode button (active-low, async)
//   KEY_INC_N   : raw increment button (active-low, async)
//   SEC_EN      : one-cycle seconds enable, RUN mode only
//   SEC_CLR     : level clear to the seconds counter while setting minutes
//   MIN_INC     : one-cycle minute-increment strobe (SET_MIN)
//   HOUR_INC    : one-cycle hour-increment strobe (SET_HOUR)
//   MODE        : 0=RUN, 1=SET_HOUR, 2=SET_MIN
//   BLINK       : 1 Hz square wave, high in the first half of each second
module clock_ctrl
  import clock24_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned DB_CNT   = DB_CNT_DEF,
  parameter int unsigned REP_DIV  = REP_DIV_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_MODE_N,
  input  logic       KEY_INC_N,
  output logic       SEC_EN,
  output logic       SEC_CLR,
  output logic       MIN_INC,
  output logic       HOUR_INC,
  output logic [1:0] MODE,
  output logic       BLINK
);

  localparam int unsigned    PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned    RW        = (REP_DIV > 1) ? $clog2(REP_DIV) : 1;
  localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  TICK_HALF = PW'(TICK_DIV / 2);
  localparam logic [RW-1:0]  REP_LAST  = RW'(REP_DIV - 1);

  mode_t         mode_q, mode_nxt;
  logic [PW-1:0] presc_q, presc_nxt;
  logic [RW-1:0] rep_q, rep_nxt;
  logic          mode_press, inc_press, inc_held;
  logic          mode_held_unused;  // only the press edge of MODE matters
  logic          tick, restart, set_mode, rep_fire, inc_evt;

  key_debounce #(.DB_CNT(DB_CNT)) u_key_mode (
    .CLK     (CLK),
    .RST     (RST),
    .KEY_N   (KEY_MODE_N),
    .PRESSED (mode_held_unused),
    .PRESS   (mode_press)
  );

  key_debounce #(.DB_CNT(DB_CNT)) u_key_inc (
    .CLK     (CLK),
    .RST     (RST),
    .KEY_N   (KEY_INC_N),
    .PRESSED (inc_held),
    .PRESS   (inc_press)
  );

  always_comb begin
    mode_nxt = MODE_RUN;
    case (mode_q)
      MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN:
        mode_nxt = mode_press ? next_mode(mode_q) : mode_q;
      default:
        mode_nxt = MODE_RUN;
    endcase

    // Leaving SET_MIN restarts the second so counting resumes from :00.
    restart = mode_press && (mode_q == MODE_SET_MIN);
    tick    = (presc_q == TICK_LAST);
    if (restart || tick) presc_nxt = '0;
    else                 presc_nxt = presc_q + 1'b1;

    set_mode = (mode_q == MODE_SET_HOUR) || (mode_q == MODE_SET_MIN);

    // Repeat counter runs only on held, non-event cycles in a set mode;
    // a MODE press takes priority and discards a coincident INC press.
    rep_fire = 1'b0;
    rep_nxt  = '0;
    if (set_mode && inc_held && !mode_press && !inc_press) begin
      if (rep_q == REP_LAST) rep_fire = 1'b1;
      else                   rep_nxt  = rep_q + 1'b1;
    end

    inc_evt = set_mode && !mode_press && (inc_press || rep_fire);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q   <= MODE_RUN;
      presc_q  <= '0;
      rep_q    <= '0;
      SEC_EN   <= 1'b0;
      SEC_CLR  <= 1'b0;
      MIN_INC  <= 1'b0;
      HOUR_INC <= 1'b0;
      BLINK    <= 1'b1;
    end else begin
      mode_q   <= mode_nxt;
      presc_q  <= presc_nxt;
      rep_q    <= rep_nxt;
      // Gated on the mode being entered so no pulse leaks into a set mode.
      SEC_EN   <= tick && !restart && (mode_nxt == MODE_RUN);
      SEC_CLR  <= (mode_nxt == MODE_SET_MIN);
      MIN_INC  <= inc_evt && (mode_q == MODE_SET_MIN);
      HOUR_INC <= inc_evt && (mode_q == MODE_SET_HOUR);
      BLINK    <= (presc_nxt < TICK_HALF);
    end
  end

  assign MODE = mode_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed and random stimulus for clock_ctrl, checked every
// cycle against a timeline model derived from the behavioural rules.
module tb_clock_ctrl;

  localparam int TICK = 10;
  localparam int DB   = 4;
  localparam int REP  = 8;
  localparam int HMAX = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kmn = 1'b1;
  logic       kin = 1'b1;
  logic       sec_en, sec_clr, min_inc, hour_inc, blink;
  logic [1:0] mode;

  clock_ctrl #(
    .TICK_DIV (TICK),
    .DB_CNT   (DB),
    .REP_DIV  (REP)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .KEY_MODE_N (kmn),
    .KEY_INC_N  (kin),
    .SEC_EN     (sec_en),
    .SEC_CLR    (sec_clr),
    .MIN_INC    (min_inc),
    .HOUR_INC   (hour_inc),
    .MODE       (mode),
    .BLINK      (blink)
  );

  always #5 clk = ~clk;

  int total, bad, n;
  int hour_seen, min_seen, sec_seen;
  int h0, m0, s0;

  // Reference model state: raw key history per edge, accepted key levels,
  // edge at which each pending press takes effect, mode, second origin.
  bit raw_m [HMAX];
  bit raw_i [HMAX];
  bit deb_m, deb_i;
  int vf_m, vf_i, pend_m, pend_i;
  int m_mode, t0, anchor;
  bit e_sec, e_clr, e_min, e_hour, e_blink;
  int e_mode;

  int lm, li;
  bit vm, vi;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  // A key level is accepted at edge e when the DB samples reaching the
  // debouncer (raw delayed two edges) all disagree with the current level,
  // and none of them predate the last acceptance/reset.
  function automatic bit flip_due(input int e, input int vf, input bit deb, input bit is_inc);
    int lo;
    lo = e - DB - 1;
    if (lo < vf || lo < 0) return 1'b0;
    for (int j = lo; j <= e - 2; j++) begin
      bit r;
      r = is_inc ? raw_i[j] : raw_m[j];
      if (r == deb) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input bit r, input bit km, input bit ki);
    int x, om, cnt;
    bit mev, iev, held, strobe, fm, fi;
    x = n;
    strobe = 1'b0;
    if (r) begin
      raw_m[x] = 1'b1;
      raw_i[x] = 1'b1;
      if (x > 0) begin
        raw_m[x-1] = 1'b1;
        raw_i[x-1] = 1'b1;
      end
      deb_m = 1'b1; deb_i = 1'b1;
      vf_m = x - 1; vf_i = x - 1;
      pend_m = -1; pend_i = -1;
      m_mode = 0; t0 = x; anchor = x;
    end else begin
      raw_m[x] = km;
      raw_i[x] = ki;
      mev  = (pend_m == x);
      iev  = (pend_i == x);
      held = !deb_i;
      om   = m_mode;
      if (mev) begin
        m_mode = (om + 1) % 3;
        if (om == 2) t0 = x;
        anchor = x;
      end else if (om == 0 || !held || iev) begin
        anchor = x;
        strobe = iev && (om != 0);
      end else if ((x - anchor) % REP == 0) begin
        strobe = 1'b1;
      end
      fm = flip_due(x, vf_m, deb_m, 1'b0);
      fi = flip_due(x, vf_i, deb_i, 1'b1);
      if (fm) begin
        deb_m = !deb_m;
        vf_m  = x - 1;
        if (!deb_m) pend_m = x + 2;
      end
      if (fi) begin
        deb_i = !deb_i;
        vf_i  = x - 1;
        if (!deb_i) pend_i = x + 2;
      end
    end
    cnt     = (x - t0) % TICK;
    e_mode  = m_mode;
    e_sec   = (x > t0) && (cnt == 0) && (m_mode == 0);
    e_blink = (cnt < TICK / 2);
    e_clr   = (m_mode == 2);
    e_hour  = strobe && (m_mode == 1);
    e_min   = strobe && (m_mode == 2);
  endtask

  task automatic cyc(input bit r, input bit km, input bit ki);
    logic excl;
    rst = r;
    kmn = km;
    kin = ki;
    @(posedge clk);
    #1;
    model_edge(r, km, ki);
    chk("MODE",     mode,     2'(e_mode));
    chk("SEC_EN",   sec_en,   {1'b0, e_sec});
    chk("SEC_CLR",  sec_clr,  {1'b0, e_clr});
    chk("MIN_INC",  min_inc,  {1'b0, e_min});
    chk("HOUR_INC", hour_inc, {1'b0, e_hour});
    chk("BLINK",    blink,    {1'b0, e_blink});
    excl = ((int'(sec_en) + int'(min_inc) + int'(hour_inc)) <= 1);
    chk("STROBE_EXCL", {1'b0, excl}, 2'd1);
    hour_seen += int'(hour_inc);
    min_seen  += int'(min_inc);
    sec_seen  += int'(sec_en);
    n++;
  endtask

  task automatic run(input int cnt, input bit km, input bit ki);
    repeat (cnt) cyc(1'b0, km, ki);
  endtask

  initial begin
    total = 0; bad = 0; n = 0;
    hour_seen = 0; min_seen = 0; sec_seen = 0;
    for (int i = 0; i < HMAX; i++) begin
      raw_m[i] = 1'b1;
      raw_i[i] = 1'b1;
    end
    deb_m = 1'b1; deb_i = 1'b1;
    vf_m = 0; vf_i = 0; pend_m = -1; pend_i = -1;
    m_mode = 0; t0 = 0; anchor = 0;

    // Reset, then free-run in RUN: ticks at 10-cycle spacing.
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    s0 = sec_seen;
    run(35, 1'b1, 1'b1);
    chk_n("SEC_PULSES_RUN", sec_seen - s0, 3);

    // Short MODE glitch is rejected.
    run(2, 1'b0, 1'b1);
    run(12, 1'b1, 1'b1);
    chk("GLITCH_MODE", mode, 2'd0);

    // Real MODE press -> SET_HOUR.
    run(10, 1'b0, 1'b1);
    run(12, 1'b1, 1'b1);
    chk("MODE_SET_HOUR", mode, 2'd1);

    // Held INC in SET_HOUR: press strobe + 3 repeats, no MIN_INC.
    h0 = hour_seen; m0 = min_seen; s0 = sec_seen;
    run(30, 1'b1, 1'b0);
    run(20, 1'b1, 1'b1);
    chk_n("HOUR_REPEAT", hour_seen - h0, 4);
    chk_n("MIN_IN_SET_HOUR", min_seen - m0, 0);
    chk_n("SEC_IN_SET_HOUR", sec_seen - s0, 0);

    // To SET_MIN, tap INC once.
    run(10, 1'b0, 1'b1);
    run(12, 1'b1, 1'b1);
    chk("MODE_SET_MIN", mode, 2'd2);
    chk("SEC_CLR_SET_MIN", sec_clr, 2'd1);
    m0 = min_seen;
    run(6, 1'b1, 1'b0);
    run(15, 1'b1, 1'b1);
    chk_n("MIN_TAP", min_seen - m0, 1);

    // Back to RUN: prescaler restarts, first tick a full second later.
    run(10, 1'b0, 1'b1);
    run(25, 1'b1, 1'b1);
    chk("MODE_RUN_AGAIN", mode, 2'd0);

    // To SET_HOUR, then both keys together: MODE wins, no increment.
    run(10, 1'b0, 1'b1);
    run(12, 1'b1, 1'b1);
    h0 = hour_seen; m0 = min_seen;
    run(8, 1'b0, 1'b0);
    run(20, 1'b1, 1'b1);
    chk("MODE_BOTH_KEYS", mode, 2'd2);
    chk_n("HOUR_BOTH_KEYS", hour_seen - h0, 0);
    chk_n("MIN_BOTH_KEYS", min_seen - m0, 0);

    // Reset in SET_MIN with INC held.
    run(20, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("MODE_AFTER_RST", mode, 2'd0);
    m0 = min_seen;
    run(20, 1'b1, 1'b0);
    run(10, 1'b1, 1'b1);
    chk_n("MIN_AFTER_RST", min_seen - m0, 0);

    // Random key activity with occasional resets.
    lm = 0; li = 0; vm = 1'b1; vi = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (lm == 0) begin
        vm = bit'($urandom_range(0, 1));
        lm = int'($urandom_range(1, 14));
      end
      if (li == 0) begin
        vi = bit'($urandom_range(0, 1));
        li = int'($urandom_range(1, 14));
      end
      lm--;
      li--;
      cyc(($urandom_range(0, 249) == 0), vm, vi);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Control front-end of the clock24 design; sits directly upstream of the seconds, minutes and hours counters.
- Generates the 1 Hz seconds enable from the 50 MHz board clock.
- Debounces the two DE1 push-buttons and runs a RUN/SET_HOUR/SET_MIN mode FSM.
- Emits the enable, clear and increment strobes the counter chain consumes, plus mode and blink signals for the 7-segment display stage.

Parameters:
- TICK_DIV, 50_000_000, clock cycles per SEC_EN pulse (1 Hz at 50 MHz)
- DB_CNT, 1_000_000, consecutive stable cycles needed to accept a key change (20 ms)
- REP_DIV, 12_500_000, auto-repeat period for a held INC key in set modes (4 Hz)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- KEY_MODE_N  in  1  raw mode button, active-low, asynchronous to CLK
- KEY_INC_N  in  1  raw increment button, active-low, asynchronous to CLK
- SEC_EN  out  1  one-cycle seconds enable; RUN mode only
- SEC_CLR  out  1  level clear to the seconds counter
- MIN_INC  out  1  one-cycle minute-increment strobe
- HOUR_INC  out  1  one-cycle hour-increment strobe
- MODE  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN
- BLINK  out  1  1 Hz square wave, high in first half of each second; display blanks the field being set

Behaviour:
- All state updates on posedge CLK; RST is sampled synchronously.
- Reset values:
  - MODE=RUN; SEC_EN, SEC_CLR, MIN_INC, HOUR_INC = 0; BLINK=1.
  - Prescaler, debounce and repeat counters = 0; debounced keys = released (1).
- RST mid-operation: same reset state on the next edge; any in-flight strobe is dropped.
- Prescaler:
  - Free-runs 0..TICK_DIV-1 and wraps to 0.
  - Tick when count==TICK_DIV-1.
  - BLINK = (count < TICK_DIV/2), registered.
- SEC_EN:
  - Registered; high for exactly one cycle per tick, and only while MODE==RUN.
  - Ticks in set modes are suppressed, not queued.
- Key path, per key:
  - 2-FF synchroniser, then debounce counter.
  - The counter increments each cycle the synced value differs from the debounced value and clears when they match.
  - At DB_CNT consecutive mismatches the debounced value takes the synced value and the counter clears.
  - A release edge generates no event.
- Press-to-output latency: a press first sampled low at edge k produces the output strobe (state change or MIN_INC/HOUR_INC) high in the cycle after edge k+DB_CNT+3.
- Glitch rejection: a glitch shorter than DB_CNT cycles produces no event.
- FSM, advancing on a MODE press event:
  - RUN -> SET_HOUR -> SET_MIN -> RUN.
  - Encoding 2'b11 is unreachable; if ever present, go to RUN on the next cycle.
- INC press event:
  - SET_HOUR: one-cycle HOUR_INC.
  - SET_MIN: one-cycle MIN_INC.
  - RUN: ignored.
- Auto-repeat:
  - Runs while INC is held (debounced pressed) in a set mode.
  - Repeat counter clears on the press event and counts each held cycle.
  - At REP_DIV-1 it emits one further strobe and wraps.
  - Releasing the key or changing mode clears the counter.
- Simultaneous MODE and INC events in the same cycle: MODE wins, INC event discarded, repeat counter cleared.
- SEC_CLR:
  - High for every cycle MODE==SET_MIN, holding seconds at 00 while minutes are set.
  - Low in RUN and SET_HOUR.
- SET_MIN -> RUN transition:
  - Prescaler forced to 0 on the same edge.
  - First SEC_EN after re-entering RUN arrives exactly TICK_DIV cycles later, so counting restarts from a full second.
- Strobe exclusivity: at most one of SEC_EN, MIN_INC, HOUR_INC is high in any cycle (guaranteed by mode gating).

Decomposition:
- Package clock24_pkg:
  - typedef enum logic [1:0] mode_t {MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN}.
  - Default constants CLK_HZ, TICK_DIV_DEF, DB_CNT_DEF, REP_DIV_DEF.
  - Shared with the display stage, which decodes MODE.
- Sub-module key_debounce:
  - Parameter DB_CNT.
  - Ports CLK, RST, KEY_N, PRESSED (level), PRESS (one-cycle pulse).
  - Instantiated twice.
- Prescaler, FSM and repeat logic stay in clock_ctrl.

Test Plan (TICK_DIV=10, DB_CNT=4, REP_DIV=8):
- Reset, keys released, run 35 cycles -> SEC_EN single-cycle pulses 10 cycles apart, MODE=0, SEC_CLR=0, BLINK high 5 cycles / low 5 cycles.
- KEY_MODE_N low for 2 cycles then high -> no MODE change and no strobes. Low for 10 cycles -> MODE=1 exactly DB_CNT+3=7 cycles after the first low sample; SEC_EN stops.
- In SET_HOUR, hold KEY_INC_N low 30 cycles -> first HOUR_INC at +7, repeats every 8 cycles while held (4 pulses), none after release, MIN_INC never asserts.
- MODE press to SET_MIN -> SEC_CLR high throughout. INC tap -> one MIN_INC. Next MODE press -> MODE=0, SEC_CLR low, first SEC_EN exactly 10 cycles after the transition.
- Both keys pressed on the same cycle in SET_HOUR -> MODE=2, no HOUR_INC and no MIN_INC from that press.
- Assert RST for 1 cycle while in SET_MIN with INC held -> next cycle MODE=0, all strobes 0; no MIN_INC until a fresh, fully debounced press.
